regfile_writeback_arbiter: RTL and testbench

//  Write-side front end of RegisterFile: merges ALU and load-return writebacks onto the single

---
 rtl/regfile_writeback_arbiter.sv | 137 +++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter.sv
// Merges ALU and load-return writebacks onto the single RegisterFile write port.
// Losing loads queue in order; pend flags tell decode a source register is still in flight.
module regfile_writeback_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_wen,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     ld_valid,
  input  logic [4:0]               ld_rd,
  input  logic [XLEN-1:0]          ld_data,
  output logic                     ld_ready,
  input  logic [4:0]               readreg1,
  input  logic [4:0]               readreg2,
  output logic                     pend1,
  output logic                     pend2,
  output logic                     regwrite,
  output logic [4:0]               writereg,
  output logic [XLEN-1:0]          writedata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  logic [4:0]      r_fifo_rd   [DEPTH];
  logic [XLEN-1:0] r_fifo_data [DEPTH];
  logic [AW-1:0]   r_rptr;
  logic [AW-1:0]   r_wptr;
  logic [AW:0]     r_count;
  logic            r_regwrite;
  logic [4:0]      r_writereg;
  logic [XLEN-1:0] r_writedata;

  logic            w_alu;
  logic            w_acc;
  logic            w_ld_ok;
  logic            w_empty;
  logic            w_pop;
  logic            w_bypass;
  logic            w_push;
  logic            w_sel_valid;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;
  logic            w_hit1;
  logic            w_hit2;

  assign ld_ready = !rst && (r_count < LP_DEPTH);
  assign w_alu    = alu_wen && (alu_rd != 5'd0);
  assign w_acc    = ld_valid && ld_ready;
  assign w_ld_ok  = w_acc && (ld_rd != 5'd0);
  assign w_empty  = (r_count == '0);
  assign w_pop    = !w_alu && !w_empty;
  assign w_bypass = !w_alu && w_empty && w_ld_ok;
  assign w_push   = w_ld_ok && !w_bypass;

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = 5'd0;
    w_sel_data  = '0;
    priority case (1'b1)
      w_alu: begin
        w_sel_valid = 1'b1;
        w_sel_rd    = alu_rd;
        w_sel_data  = alu_data;
      end
      !w_empty: begin
        w_sel_valid = 1'b1;
        w_sel_rd    = r_fifo_rd[r_rptr];
        w_sel_data  = r_fifo_data[r_rptr];
      end
      w_ld_ok: begin
        w_sel_valid = 1'b1;
        w_sel_rd    = ld_rd;
        w_sel_data  = ld_data;
      end
      default: w_sel_valid = 1'b0;
    endcase
  end

  // Entry i is live when its distance from the read pointer is below count
  always_comb begin
    logic [AW-1:0] off;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - r_rptr;
      if ({1'b0, off} < r_count) begin
        if (r_fifo_rd[i] == readreg1) w_hit1 = 1'b1;
        if (r_fifo_rd[i] == readreg2) w_hit2 = 1'b1;
      end
    end
  end

  assign pend1 = (readreg1 != 5'd0) &&
                 (w_hit1 || (r_regwrite && r_writereg == readreg1));
  assign pend2 = (readreg2 != 5'd0) &&
                 (w_hit2 || (r_regwrite && r_writereg == readreg2));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wptr]   <= ld_rd;
      r_fifo_data[r_wptr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr      <= '0;
      r_wptr      <= '0;
      r_count     <= '0;
      r_regwrite  <= 1'b0;
      r_writereg  <= 5'd0;
      r_writedata <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count    <= r_count + {{AW{1'b0}}, w_push}
                            - {{AW{1'b0}}, w_pop};
      r_regwrite <= w_sel_valid;
      if (w_sel_valid) begin
        r_writereg  <= w_sel_rd;
        r_writedata <= w_sel_data;
      end
    end
  end

  assign regwrite  = r_regwrite;
  assign writereg  = r_writereg;
  assign writedata = r_writedata;
  assign count     = r_count;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Bench for regfile_writeback_arbiter: directed scenarios plus random
// traffic, all checked cycle by cycle against a queue-based model.
module tb_regfile_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_wen;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;
  logic [4:0]      readreg1;
  logic [4:0]      readreg2;
  logic            pend1;
  logic            pend2;
  logic            regwrite;
  logic [4:0]      writereg;
  logic [XLEN-1:0] writedata;
  logic [2:0]      count;

  regfile_writeback_arbiter #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .alu_wen(alu_wen), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_ready(ld_ready),
    .readreg1(readreg1), .readreg2(readreg2),
    .pend1(pend1), .pend2(pend2),
    .regwrite(regwrite), .writereg(writereg),
    .writedata(writedata), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return !rst && (q.size() < DEPTH);
  endfunction

  function automatic logic m_pend(input logic [4:0] r);
    logic hit;
    hit = m_rw && (m_wr == r);
    foreach (q[i]) if (q[i].rd == r) hit = 1'b1;
    return (r != 5'd0) && hit;
  endfunction

  // Check current outputs, advance model, cross one clock edge
  task automatic tick();
    logic acc;
    logic ld_ok;
    logic was_empty;
    ent_t e;
    #1;
    chk("ld_ready",  32'(ld_ready),  32'(m_ready()));
    chk("regwrite",  32'(regwrite),  32'(m_rw));
    chk("writereg",  32'(writereg),  32'(m_wr));
    chk("writedata", writedata,      m_wd);
    chk("count",     32'(count),     32'(q.size()));
    chk("pend1",     32'(pend1),     32'(m_pend(readreg1)));
    chk("pend2",     32'(pend2),     32'(m_pend(readreg2)));
    if (rst) begin
      q.delete();
      m_rw = 1'b0;
      m_wr = 5'd0;
      m_wd = '0;
    end else begin
      acc       = ld_valid && m_ready();
      ld_ok     = acc && (ld_rd != 5'd0);
      was_empty = (q.size() == 0);
      if (alu_wen && alu_rd != 5'd0) begin
        m_rw = 1'b1; m_wr = alu_rd; m_wd = alu_data;
      end else if (!was_empty) begin
        e = q.pop_front();
        m_rw = 1'b1; m_wr = e.rd; m_wd = e.d;
      end else if (ld_ok) begin
        m_rw = 1'b1; m_wr = ld_rd; m_wd = ld_data;
        ld_ok = 1'b0;
      end else begin
        m_rw = 1'b0;
      end
      if (ld_ok) begin
        e.rd = ld_rd; e.d = ld_data;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    alu_wen  = 1'b0; alu_rd  = 5'd0; alu_data = '0;
    ld_valid = 1'b0; ld_rd   = 5'd0; ld_data  = '0;
  endtask

  initial begin
    idle();
    readreg1 = 5'd0; readreg2 = 5'd0;
    rst = 1'b1; ld_valid = 1'b1; ld_rd = 5'd4;
    m_rw = 1'b0; m_wr = 5'd0; m_wd = '0;
    @(posedge clk);
    @(negedge clk);
    tick();
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    idle();
    #1 chk("rel_ready", 32'(ld_ready), 32'd1);

    // Lone load
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hDEADBEEF;
    readreg1 = 5'd5;
    tick();
    idle();
    chk("lone_wd", writedata, 32'hDEADBEEF);
    chk("lone_pend", 32'(pend1), 32'd1);
    tick();
    chk("lone_pend_off", 32'(pend1), 32'd0);

    // Collision
    readreg2 = 5'd7;
    alu_wen = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h22;
    tick();
    idle();
    chk("col_wr1", 32'(writereg), 32'd3);
    chk("col_cnt", 32'(count), 32'd1);
    tick();
    chk("col_wr2", 32'(writereg), 32'd7);
    tick();
    chk("col_pend_off", 32'(pend2), 32'd0);

    // Fill under continuous ALU traffic
    for (int k = 0; k < 5; k++) begin
      alu_wen = 1'b1; alu_rd = 5'(1 + k % 3); alu_data = 32'(k);
      ld_valid = 1'b1; ld_rd = 5'(8 + k); ld_data = 32'h100 + 32'(k);
      tick();
      if (k == 3) begin
        chk("fill_cnt", 32'(count), 32'd4);
        chk("fill_rdy", 32'(ld_ready), 32'd0);
      end
    end
    alu_wen = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (ld_valid && m_ready()) begin
        tick();
        ld_valid = 1'b0;
      end else begin
        tick();
      end
      if (k < 4) chk("drain_wr", 32'(writereg), 32'(8 + k));
    end
    idle();

    // x0 handling
    readreg1 = 5'd0;
    alu_wen = 1'b1; alu_rd = 5'd0; alu_data = 32'd5;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h9;
    tick();
    idle();
    chk("x0_rw", 32'(regwrite), 32'd0);
    chk("x0_cnt", 32'(count), 32'd0);

    // Mid-drain reset
    for (int k = 0; k < 3; k++) begin
      alu_wen = 1'b1; alu_rd = 5'd2; alu_data = 32'(k);
      ld_valid = 1'b1; ld_rd = 5'(20 + k); ld_data = 32'(k);
      tick();
    end
    idle();
    chk("mid_cnt3", 32'(count), 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_cnt0", 32'(count), 32'd0);
    chk("mid_rw", 32'(regwrite), 32'd0);
    tick();
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 59) == 0);
      alu_wen  = 1'($urandom_range(0, 2) != 0);
      alu_rd   = 5'($urandom_range(0, 7));
      alu_data = $urandom;
      ld_valid = 1'($urandom_range(0, 1));
      ld_rd    = 5'($urandom_range(0, 7));
      ld_data  = $urandom;
      readreg1 = 5'($urandom_range(0, 7));
      readreg2 = 5'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    idle();
    for (int n = 0; n < 6; n++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
